rv_fetch: RTL and testbench
===========================

RV_FETCH -- requirements
Module: rv_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0013 (ADDI x0,x0,0), value of out_instr when no instruction is held.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr_bus  output  32  word index to program ROM, = fetch_pc >> 2, zero-extended.
REQ-006 data_bus  input  32  ROM word, combinationally valid in the same cycle as addr_bus.
REQ-007 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-008 redirect_pc  input  32  byte target of redirect.
REQ-009 out_valid  output  1  head instruction valid to decode.
REQ-010 out_ready  input  1  decode accepts head this cycle.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc  output  32  byte address of head instruction.
REQ-013 misalign  output  1  one-cycle pulse: accepted redirect_pc[1:0] != 0.

Function
REQ-014 State: fetch_pc (32b, byte), 2-entry FIFO of {instr, pc}, count (0..2), rd/wr pointers.
REQ-015 fetch_pc[1:0] SHALL always be 2'b00.
REQ-016 pop = out_valid && out_ready; push = !redirect_valid && (count < 2 || pop).
REQ-017 On push: FIFO captures {data_bus, fetch_pc}; fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-018 No push: fetch_pc holds; addr_bus holds.
REQ-019 count next = count + push - pop; push and pop in same cycle with count==2 SHALL keep count 2 and lose no entry.
REQ-020 out_valid = (count != 0); out_instr/out_pc = head entry; when count==0, out_instr = NOP_WORD and out_pc = fetch_pc.
REQ-021 Head SHALL remain stable while out_valid && !out_ready.
REQ-022 Fetch-to-output latency: word presented on data_bus at edge N appears on out_instr after edge N when FIFO was empty (1 cycle).
REQ-023 Redirect (priority over push and pop): FIFO flushed (count<=0), fetch_pc <= {redirect_pc[31:2], 2'b00}, pop ignored, no push that cycle.
REQ-024 misalign <= 1 for one cycle following a redirect with redirect_pc[1:0] != 0, else 0.
REQ-025 Back-to-back redirects: last one wins; each flushes.
REQ-026 Sustained throughput with out_ready held 1: one instruction per cycle, no bubbles after the first.

Reset
REQ-027 While rst=1: fetch_pc = RESET_PC & ~3, count = 0, pointers 0, out_valid = 0, out_instr = NOP_WORD, out_pc = RESET_PC & ~3, misalign = 0.
REQ-028 Reset asserted mid-stream SHALL discard FIFO contents and any pending redirect immediately (asynchronously).
REQ-029 First push occurs at first rising edge with rst=0.

Verification
REQ-030 ROM[0]=32'h0010_0093, ROM[1]=ROM[2]=32'h0010_8093, out_ready=1, release rst -> out_pc 0,4,8 on consecutive cycles with matching words, addr_bus 0,1,2,3.
REQ-031 out_ready=0 for 5 cycles after reset -> count 2, addr_bus stalls at 2, out_instr=32'h0010_0093, out_pc=0 stable; ready=1 -> pcs 0,4,8 without gaps or duplicates.
REQ-032 redirect_valid with redirect_pc=32'h40 while count=2 and out_ready=1 -> next cycle out_valid=0, addr_bus=16; following cycle out_pc=32'h40.
REQ-033 redirect_pc=32'h46 -> misalign pulses 1 cycle, fetch resumes at 32'h44 (addr_bus=17).
REQ-034 redirect_pc=32'hFFFF_FFFC, out_ready=1 -> out_pc FFFF_FFFC then 0000_0000 (addr_bus wraps to 0).
REQ-035 rst asserted between edges while count=2 -> out_valid=0 and out_instr=32'h0000_0013 before next edge; addr_bus=0.

Source files
------------

// File: rtl/rv_fetch.sv
// Instruction fetch stage: walks a program ROM word by word and buffers up to
// two {instr, pc} pairs for decode, with flush-and-restart on redirect.
module rv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] addr_bus,
  input  logic [31:0] data_bus,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign
);

  // The fetch pointer is kept as a word index, so its byte form can never be
  // misaligned and the +4 step wraps at 2^32 bytes for free.
  logic [29:0] fetch_word;
  logic [31:0] fetch_pc;

  logic [31:0] instr_q [2];
  logic [31:0] pc_q    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic push;
  logic pop;

  assign fetch_pc = {fetch_word, 2'b00};
  assign addr_bus = {2'b00, fetch_word};

  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? instr_q[rd_ptr] : NOP_WORD;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : fetch_pc;

  assign pop  = out_valid && out_ready;
  assign push = !redirect_valid && ((count != 2'd2) || pop);

  // Redirect outranks everything: it flushes the buffer and drops any pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_word <= RESET_PC[31:2];
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      misalign   <= 1'b0;
    end else if (redirect_valid) begin
      fetch_word <= redirect_pc[31:2];
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      misalign   <= (redirect_pc[1:0] != 2'b00);
    end else begin
      misalign <= 1'b0;
      if (push) begin
        fetch_word <= fetch_word + 30'd1;
        wr_ptr     <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; count gates whether it is ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= data_bus;
      pc_q[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_rv_fetch.sv
// Directed bench for rv_fetch: ROM model on the address bus, one task per scenario.
module tb_rv_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] addr_bus;
  logic [31:0] data_bus;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign;

  int errors;
  int checks;

  localparam logic [31:0] NOP = 32'h0000_0013;

  rv_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .addr_bus       (addr_bus),
    .data_bus       (data_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .misalign       (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program ROM: the three listed words, then a distinct word per index.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0010_0093;
    if (a == 32'd1 || a == 32'd2) return 32'h0010_8093;
    return 32'hC000_0000 ^ a;
  endfunction

  assign data_bus = rom_word(addr_bus);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", out_instr, NOP); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (addr_bus !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", addr_bus); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    checks++; if (addr_bus !== 32'd0) begin errors++; $display("[TB] FAIL stream_addr0: got %h expected 0", addr_bus); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("[TB] FAIL stream_pc[%0d]: got %h expected %h", i, out_pc, 32'(4 * i)); end
      checks++; if (out_instr !== rom_word(32'(i))) begin errors++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", i, out_instr, rom_word(32'(i))); end
      checks++; if (addr_bus !== 32'(i + 1)) begin errors++; $display("[TB] FAIL stream_addr[%0d]: got %h expected %h", i, addr_bus, 32'(i + 1)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++; if (addr_bus !== ((k < 2) ? 32'(k) : 32'd2)) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %h expected %h", k, addr_bus, (k < 2) ? 32'(k) : 32'd2); end
      checks++; if (out_instr !== 32'h0010_0093) begin errors++; $display("[TB] FAIL stall_instr[%0d]: got %h expected 00100093", k, out_instr); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected 0", k, out_pc); end
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("[TB] FAIL drain_pc[%0d]: got %h expected %h", i, out_pc, 32'(4 * i)); end
      checks++; if (out_instr !== rom_word(32'(i))) begin errors++; $display("[TB] FAIL drain_instr[%0d]: got %h expected %h", i, out_instr, rom_word(32'(i))); end
      checks++; if (addr_bus !== 32'(i + 2)) begin errors++; $display("[TB] FAIL drain_addr[%0d]: got %h expected %h", i, addr_bus, 32'(i + 2)); end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush: got %b expected 0", out_valid); end
    checks++; if (addr_bus !== 32'd16) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 10", addr_bus); end
    checks++; if (out_instr !== NOP) begin errors++; $display("[TB] FAIL redir_nop: got %h expected %h", out_instr, NOP); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL redir_misalign: got %b expected 0", misalign); end
    step();
    checks++; if (out_pc !== 32'h40) begin errors++; $display("[TB] FAIL redir_pc: got %h expected 40", out_pc); end
    checks++; if (out_instr !== rom_word(32'd16)) begin errors++; $display("[TB] FAIL redir_instr: got %h expected %h", out_instr, rom_word(32'd16)); end
    checks++; if (addr_bus !== 32'd17) begin errors++; $display("[TB] FAIL redir_addr2: got %h expected 11", addr_bus); end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 32'h46;
    step();
    redirect_valid = 1'b0;
    checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL mis_pulse: got %b expected 1", misalign); end
    checks++; if (addr_bus !== 32'd17) begin errors++; $display("[TB] FAIL mis_addr: got %h expected 11", addr_bus); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mis_flush: got %b expected 0", out_valid); end
    step();
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL mis_clear: got %b expected 0", misalign); end
    checks++; if (out_pc !== 32'h44) begin errors++; $display("[TB] FAIL mis_pc: got %h expected 44", out_pc); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    checks++; if (addr_bus !== 32'd64) begin errors++; $display("[TB] FAIL b2b_addr1: got %h expected 40", addr_bus); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL b2b_mis1: got %b expected 0", misalign); end
    redirect_pc = 32'h203;
    step();
    redirect_valid = 1'b0;
    checks++; if (addr_bus !== 32'd128) begin errors++; $display("[TB] FAIL b2b_addr2: got %h expected 80", addr_bus); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_flush: got %b expected 0", out_valid); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mis2: got %b expected 1", misalign); end
    step();
    checks++; if (out_pc !== 32'h200) begin errors++; $display("[TB] FAIL b2b_pc: got %h expected 200", out_pc); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (addr_bus !== 32'h3FFF_FFFF) begin errors++; $display("[TB] FAIL wrap_addr0: got %h expected 3fffffff", addr_bus); end
    step();
    checks++; if (out_pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_pc0: got %h expected fffffffc", out_pc); end
    checks++; if (out_instr !== rom_word(32'h3FFF_FFFF)) begin errors++; $display("[TB] FAIL wrap_instr0: got %h expected %h", out_instr, rom_word(32'h3FFF_FFFF)); end
    checks++; if (addr_bus !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr1: got %h expected 0", addr_bus); end
    step();
    checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc1: got %h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0010_0093) begin errors++; $display("[TB] FAIL wrap_instr1: got %h expected 00100093", out_instr); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    step();
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst_prefill: got %b expected 1", out_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h87;
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL arst_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== NOP) begin errors++; $display("[TB] FAIL arst_instr: got %h expected %h", out_instr, NOP); end
    checks++; if (addr_bus !== 32'h0) begin errors++; $display("[TB] FAIL arst_addr: got %h expected 0", addr_bus); end
    step();
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (misalign !== 1'b0) begin errors++; $display("[TB] FAIL arst_misalign: got %b expected 0", misalign); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("[TB] FAIL arst_restart_pc: got %h expected 0", out_pc); end
    checks++; if (out_instr !== 32'h0010_0093) begin errors++; $display("[TB] FAIL arst_restart_instr: got %h expected 00100093", out_instr); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
